// File: rtl/i2s_rx_slave.sv
// Slave-mode I2S / left-justified receiver: oversamples BCLK/LRCK/SDATA in the clk
// domain and emits coherent 24-bit left/right pairs with a one-cycle valid pulse.
module i2s_rx_slave #(
    parameter int DATA_W      = 24,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              fmt_sel,
    input  logic              i2s_bclk,
    input  logic              i2s_lrck,
    input  logic              i2s_sdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_l,
    output logic [DATA_W-1:0] out_r,
    output logic              frame_err
);

    // state     | meaning
    // IDLE      | disabled, partial data dropped, format latched
    // WAIT_SYNC | waiting for the start of a left slot (LRCK 1->0)
    // LEFT      | capturing the left slot
    // RIGHT     | capturing the right slot
    typedef enum logic [1:0] {IDLE, WAIT_SYNC, LEFT, RIGHT} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] bclk_sync, lrck_sync, sdata_sync;
    logic                   bclk_prev, lrck_prev;
    logic                   bclk_s, lrck_s, sdata_s;
    logic                   rise, boundary;

    logic                   fmt_lat;
    logic [DATA_W-1:0]      shift, shift_cap, slot_first, left_hold;
    logic                   left_valid;
    logic [CNT_W-1:0]       cnt, cnt_inc, idx;
    logic [CNT_W:0]         data_bits;
    logic                   short_slot;
    logic                   start_slot, capture, commit_l, commit_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_sync  <= '0;
            lrck_sync  <= '0;
            sdata_sync <= '0;
            bclk_prev  <= 1'b0;
            lrck_prev  <= 1'b0;
        end else begin
            bclk_sync  <= {bclk_sync[SYNC_STAGES-2:0], i2s_bclk};
            lrck_sync  <= {lrck_sync[SYNC_STAGES-2:0], i2s_lrck};
            sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], i2s_sdata};
            bclk_prev  <= bclk_s;
            if (rise) lrck_prev <= lrck_s;
        end
    end

    assign bclk_s   = bclk_sync[SYNC_STAGES-1];
    assign lrck_s   = lrck_sync[SYNC_STAGES-1];
    assign sdata_s  = sdata_sync[SYNC_STAGES-1];
    assign rise     = bclk_s & ~bclk_prev;
    assign boundary = rise && (lrck_s != lrck_prev);

    // cnt counts rises since the boundary; in I2S the boundary bit is a dummy slot
    assign cnt_inc    = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
    assign idx        = fmt_lat ? cnt_inc : cnt_inc - 1'b1;
    assign data_bits  = fmt_lat ? {1'b0, cnt} + 1'b1 : {1'b0, cnt};
    assign short_slot = data_bits < (CNT_W+1)'(DATA_W);
    assign slot_first = fmt_lat ? {sdata_s, {(DATA_W-1){1'b0}}} : '0;

    always_comb begin
        shift_cap = shift;
        for (int i = 0; i < DATA_W; i++)
            if ({1'b0, idx} == (CNT_W+1)'(DATA_W - 1 - i)) shift_cap[i] = sdata_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        start_slot = 1'b0;
        capture    = 1'b0;
        commit_l   = 1'b0;
        commit_r   = 1'b0;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:      state_next = WAIT_SYNC;
                WAIT_SYNC: if (boundary && !lrck_s) begin
                    start_slot = 1'b1;
                    state_next = LEFT;
                end
                LEFT: if (boundary) begin
                    commit_l   = 1'b1;
                    start_slot = 1'b1;
                    state_next = RIGHT;
                end else if (rise) begin
                    capture = 1'b1;
                end
                RIGHT: if (boundary) begin
                    commit_r   = 1'b1;
                    start_slot = 1'b1;
                    state_next = LEFT;
                end else if (rise) begin
                    capture = 1'b1;
                end
                default:   state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fmt_lat    <= 1'b0;
            shift      <= '0;
            cnt        <= '0;
            left_hold  <= '0;
            left_valid <= 1'b0;
            out_valid  <= 1'b0;
            out_l      <= '0;
            out_r      <= '0;
            frame_err  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            if (state == IDLE) fmt_lat <= fmt_sel;
            if (!enable || state == IDLE) begin
                shift      <= '0;
                cnt        <= '0;
                left_hold  <= '0;
                left_valid <= 1'b0;
            end else begin
                if (commit_l || commit_r) frame_err <= short_slot;
                if (commit_l) begin
                    left_hold  <= shift;
                    left_valid <= 1'b1;
                end
                if (commit_r && left_valid) begin
                    out_l      <= left_hold;
                    out_r      <= shift;
                    out_valid  <= 1'b1;
                    left_hold  <= '0;
                    left_valid <= 1'b0;
                end
                if (start_slot) begin
                    shift <= slot_first;
                    cnt   <= '0;
                end else if (capture) begin
                    shift <= shift_cap;
                    cnt   <= cnt_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_slave.sv
// Directed bench for i2s_rx_slave: drives BCLK/LRCK/SDATA slot by slot and checks
// delivered pairs, pulse spacing and frame_err counts against hand-computed values.
module tb_i2s_rx_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        fmt_sel = 1'b0;
    logic        i2s_bclk = 1'b0;
    logic        i2s_lrck = 1'b0;
    logic        i2s_sdata = 1'b0;
    logic        out_valid, frame_err;
    logic [23:0] out_l, out_r;

    i2s_rx_slave dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fmt_sel(fmt_sel),
        .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck), .i2s_sdata(i2s_sdata),
        .out_valid(out_valid), .out_l(out_l), .out_r(out_r), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [23:0] q_l[$];
    logic [23:0] q_r[$];
    int          q_t[$];
    int          n_err = 0;

    always @(negedge clk) begin
        if (out_valid) begin
            q_l.push_back(out_l);
            q_r.push_back(out_r);
            q_t.push_back(cyc);
        end
        if (frame_err) n_err++;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // one BCLK period: 4 clk low (LRCK/SDATA change here), 4 clk high
    task automatic bit_cycle(logic lr, logic d);
        i2s_bclk = 1'b0; i2s_lrck = lr; i2s_sdata = d;
        tick(4);
        i2s_bclk = 1'b1;
        tick(4);
    endtask

    // bit on rise k of a slot carrying left-aligned payload p; I2S delays by one BCLK
    function automatic logic slot_bit(logic fmt, int k, logic [31:0] p);
        if (fmt) return (k < 32) ? p[5'(31 - k)] : 1'b0;
        return (k >= 1 && k <= 32) ? p[5'(32 - k)] : 1'b0;
    endfunction

    task automatic send_slot(logic fmt, logic lr, int s, logic [31:0] p, int drop_k);
        for (int k = 0; k < s; k++) begin
            if (k == drop_k) begin
                i2s_bclk = 1'b0; i2s_lrck = lr;
                enable = 1'b0;
                tick(3);
                enable = 1'b1;
            end
            bit_cycle(lr, slot_bit(fmt, k, p));
        end
    endtask

    // n frames then a trailing left slot so the last right slot gets committed
    task automatic send_frames(logic fmt, int s, int n, logic [31:0] pl, logic [31:0] pr);
        for (int f = 0; f < n; f++) begin
            send_slot(fmt, 1'b0, s, pl, -1);
            send_slot(fmt, 1'b1, s, pr, -1);
        end
        send_slot(fmt, 1'b0, s, 32'h0, -1);
    endtask

    task automatic clear_mon();
        q_l.delete(); q_r.delete(); q_t.delete();
        n_err = 0;
    endtask

    task automatic restart(logic fmt);
        enable = 1'b0;
        fmt_sel = fmt;
        tick(3);
        enable = 1'b1;
        tick(2);
    endtask

    typedef struct {
        logic        fmt;
        int          slot;
        int          frames;
        logic [31:0] pl;
        logic [31:0] pr;
        logic [23:0] el;
        logic [23:0] er;
        int          err_pf;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{1'b0, 32, 1, {24'h123456, 8'hA5}, {24'hABCDEF, 8'hA5}, 24'h123456, 24'hABCDEF, 0};
        vecs[1] = '{1'b1, 24, 4, {24'h800001, 8'h00}, {24'h7FFFFF, 8'h00}, 24'h800001, 24'h7FFFFF, 0};
        vecs[2] = '{1'b0, 17, 2, {16'hBEEF, 16'h0}, {16'h1234, 16'h0}, 24'hBEEF00, 24'h123400, 2};
        vecs[3] = '{1'b1, 32, 2, {24'h000000, 8'hFF}, {24'hFFFFFF, 8'h00}, 24'h000000, 24'hFFFFFF, 0};

        // reset values
        tick(3);
        chk("rst out_valid", 32'(out_valid), 32'h0);
        chk("rst frame_err", 32'(frame_err), 32'h0);
        chk("rst out_l", 32'(out_l), 32'h0);
        chk("rst out_r", 32'(out_r), 32'h0);

        // reset released mid right slot, then two full I2S frames
        enable = 1'b1;
        fmt_sel = 1'b0;
        clear_mon();
        for (int k = 0; k < 32; k++) begin
            if (k == 12) rst_n = 1'b1;
            bit_cycle(1'b1, slot_bit(1'b0, k, 32'hFFFF_FFFF));
        end
        send_frames(1'b0, 32, 2, {24'h654321, 8'h00}, {24'h0F0F0F, 8'h00});
        tick(8);
        chk("rstmid count", 32'(q_l.size()), 32'd2);
        for (int i = 0; i < q_l.size() && i < 2; i++) begin
            chk("rstmid out_l", 32'(q_l[i]), 32'h654321);
            chk("rstmid out_r", 32'(q_r[i]), 32'h0F0F0F);
        end
        chk("rstmid frame_err", 32'(n_err), 32'd0);

        // table-driven frames
        for (int v = 0; v < 4; v++) begin
            restart(vecs[v].fmt);
            clear_mon();
            send_slot(vecs[v].fmt, 1'b1, vecs[v].slot, 32'h0, -1);
            send_frames(vecs[v].fmt, vecs[v].slot, vecs[v].frames, vecs[v].pl, vecs[v].pr);
            tick(8);
            chk($sformatf("vec%0d count", v), 32'(q_l.size()), 32'(vecs[v].frames));
            for (int i = 0; i < q_l.size() && i < vecs[v].frames; i++) begin
                chk($sformatf("vec%0d out_l[%0d]", v, i), 32'(q_l[i]), 32'(vecs[v].el));
                chk($sformatf("vec%0d out_r[%0d]", v, i), 32'(q_r[i]), 32'(vecs[v].er));
                if (i > 0)
                    chk($sformatf("vec%0d gap[%0d]", v, i), 32'(q_t[i] - q_t[i-1]), 32'(16 * vecs[v].slot));
            end
            chk($sformatf("vec%0d frame_err", v), 32'(n_err), 32'(vecs[v].frames * vecs[v].err_pf));
        end

        // enable dropped for 3 clk inside a left slot
        restart(1'b0);
        clear_mon();
        send_slot(1'b0, 1'b1, 32, 32'h0, -1);
        send_slot(1'b0, 1'b0, 32, {24'h111111, 8'h00}, 10);
        send_slot(1'b0, 1'b1, 32, {24'h222222, 8'h00}, -1);
        send_frames(1'b0, 32, 1, {24'h333333, 8'h00}, {24'h444444, 8'h00});
        tick(8);
        chk("endrop count", 32'(q_l.size()), 32'd1);
        if (q_l.size() > 0) begin
            chk("endrop out_l", 32'(q_l[0]), 32'h333333);
            chk("endrop out_r", 32'(q_r[0]), 32'h444444);
        end
        chk("endrop frame_err", 32'(n_err), 32'd0);

        // fmt_sel flipped to LJ while in LEFT: I2S decoding must persist
        restart(1'b0);
        clear_mon();
        send_slot(1'b0, 1'b1, 32, 32'h0, -1);
        for (int k = 0; k < 32; k++) begin
            if (k == 4) fmt_sel = 1'b1;
            bit_cycle(1'b0, slot_bit(1'b0, k, {24'hC0FFEE, 8'h5A}));
        end
        send_slot(1'b0, 1'b1, 32, {24'h13579B, 8'h5A}, -1);
        send_frames(1'b0, 32, 1, {24'h2468AC, 8'h5A}, {24'hFEDCBA, 8'h5A});
        tick(8);
        chk("fmtlock count", 32'(q_l.size()), 32'd2);
        if (q_l.size() > 1) begin
            chk("fmtlock out_l0", 32'(q_l[0]), 32'hC0FFEE);
            chk("fmtlock out_r0", 32'(q_r[0]), 32'h13579B);
            chk("fmtlock out_l1", 32'(q_l[1]), 32'h2468AC);
            chk("fmtlock out_r1", 32'(q_r[1]), 32'hFEDCBA);
        end

        // after an IDLE pass the held fmt_sel=1 selects left-justified
        restart(1'b1);
        clear_mon();
        send_slot(1'b1, 1'b1, 24, 32'h0, -1);
        send_frames(1'b1, 24, 1, {24'h5A5A5A, 8'h00}, {24'hA5A5A5, 8'h00});
        tick(8);
        chk("fmtnew count", 32'(q_l.size()), 32'd1);
        if (q_l.size() > 0) begin
            chk("fmtnew out_l", 32'(q_l[0]), 32'h5A5A5A);
            chk("fmtnew out_r", 32'(q_r[0]), 32'hA5A5A5);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
